// File: rtl/sub_arb_pkg.sv
// ============================================================================
// Module : sub_arb_pkg
// Brief  : Shared constants, types and overflow helper for the subtractor
//          sharing arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sub_arb_pkg;

    localparam int SUB_W = 32;
    localparam int SUB_N = 4;

    typedef logic [SUB_W-1:0]         sub_word_t;
    typedef logic [$clog2(SUB_N)-1:0] sub_id_t;

    // Signed overflow of a - b, judged from the sign bits of a, b and the difference.
    function automatic logic ovf_sub(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/signed_2s_comp_sub.sv
// ============================================================================
// Module : signed_2s_comp_sub
// Brief  : Combinational W-bit two's-complement subtractor, diff = a - b mod 2^W.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_2s_comp_sub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff
);

    assign diff = a + ~b + W'(1);

endmodule

`default_nettype wire

// File: rtl/sub_share_arbiter.sv
// ============================================================================
// Module : sub_share_arbiter
// Brief  : Round-robin sharing of one subtractor between N requesters, with a
//          single-entry registered response (valid/ready on both sides).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_share_arbiter
    import sub_arb_pkg::*;
#(
    parameter int N = SUB_N,
    parameter int W = SUB_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_diff,
    output logic                 rsp_ovf
);

    localparam int ID_W = $clog2(N);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_rr_nxt;
    logic [ID_W-1:0] w_grant;
    logic [ID_W:0]   w_scan;
    logic            w_found;
    logic            w_slot_free;
    logic            w_accept;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic [W-1:0]    w_diff;
    logic            w_ovf;
    logic [ID_W-1:0] r_rsp_id;
    logic [W-1:0]    r_rsp_diff;
    logic            r_rsp_ovf;

    // No grant can leak out while reset is held, even though the slot looks free.
    assign w_slot_free = (r_state == S_EMPTY) || rsp_ready;
    assign w_accept    = rst_n && w_slot_free && (|req_valid);

    // First valid requester scanning upward from the round-robin pointer.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_scan  = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(N)) begin
                w_scan = w_scan - (ID_W+1)'(N);
            end
            if (!w_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_a = req_a[i*W +: W];
                w_b = req_b[i*W +: W];
            end
        end
    end

    signed_2s_comp_sub #(
        .W    (W)
    ) u_sub (
        .a    (w_a),
        .b    (w_b),
        .diff (w_diff)
    );

    assign w_ovf    = ovf_sub(w_a[W-1], w_b[W-1], w_diff[W-1]);
    assign w_rr_nxt = (w_grant == ID_W'(N-1)) ? '0 : w_grant + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL: begin
                if (w_accept) begin
                    w_state_nxt = S_FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (r_state == S_FULL);
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Result register and pointer only move on an accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id   <= '0;
            r_rsp_diff <= '0;
            r_rsp_ovf  <= 1'b0;
            r_rr_ptr   <= '0;
        end else if (w_accept) begin
            r_rsp_id   <= w_grant;
            r_rsp_diff <= w_diff;
            r_rsp_ovf  <= w_ovf;
            r_rr_ptr   <= w_rr_nxt;
        end
    end

    assign rsp_id   = r_rsp_id;
    assign rsp_diff = r_rsp_diff;
    assign rsp_ovf  = r_rsp_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sub_share_arbiter.sv
// ============================================================================
// Module : tb_sub_share_arbiter
// Brief  : Directed scoreboard bench for sub_share_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sub_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] diff;
        logic        ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_diff;
    logic           rsp_ovf;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    sub_share_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_diff  (rsp_diff),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] diff, input logic ovf);
        q.push_back('{id: id, diff: diff, ovf: ovf});
    endtask

    // Drive one cycle's handshake inputs and check the combinational grant.
    task automatic cyc(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy, input string nm);
        @(posedge clk);
        #1;
        req_valid = v;
        rsp_ready = rr;
        #1;
        check(nm, 64'(req_ready), 64'(exp_rdy));
    endtask

    // Monitor: every response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected actual id=%0d diff=%0h expected none", rsp_id, rsp_diff);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_id",   64'(rsp_id),   64'(e.id));
                check("rsp_diff", 64'(rsp_diff), 64'(e.diff));
                check("rsp_ovf",  64'(rsp_ovf),  64'(e.ovf));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        #3;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_diff",  64'(rsp_diff),  64'd0);
        check("reset_rsp_id",    64'(rsp_id),    64'd0);
        check("reset_rsp_ovf",   64'(rsp_ovf),   64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Single request from requester 0.
        cyc(4'b0001, 1'b1, 4'b0001, "single_grant");
        set_op(0, 32'd5, 32'd7);
        push(2'd0, 32'hFFFF_FFFE, 1'b0);
        cyc(4'b0000, 1'b1, 4'b0000, "idle_after_single");

        // Overflow cases on requester 2.
        cyc(4'b0100, 1'b1, 4'b0100, "ovf1_grant");
        set_op(2, 32'h8000_0000, 32'h0000_0001);
        push(2'd2, 32'h7FFF_FFFF, 1'b1);
        cyc(4'b0100, 1'b1, 4'b0100, "ovf2_grant");
        set_op(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        push(2'd2, 32'h8000_0000, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, "idle_after_ovf");

        // Grant requester 3 so the pointer wraps back to 0.
        cyc(4'b1000, 1'b1, 4'b1000, "wrap_grant3");
        set_op(0, 32'd3,  32'd0);
        set_op(1, 32'd13, 32'd1);
        set_op(2, 32'd23, 32'd2);
        set_op(3, 32'd33, 32'd3);
        push(2'd3, 32'd30, 1'b0);

        // Rotation with all requesters valid.
        cyc(4'b1111, 1'b1, 4'b0001, "rot0"); push(2'd0, 32'd3,  1'b0);
        cyc(4'b1111, 1'b1, 4'b0010, "rot1"); push(2'd1, 32'd12, 1'b0);
        cyc(4'b1111, 1'b1, 4'b0100, "rot2"); push(2'd2, 32'd21, 1'b0);
        cyc(4'b1111, 1'b1, 4'b1000, "rot3"); push(2'd3, 32'd30, 1'b0);
        cyc(4'b1111, 1'b1, 4'b0001, "rot4"); push(2'd0, 32'd3,  1'b0);
        cyc(4'b1111, 1'b1, 4'b0010, "rot5"); push(2'd1, 32'd12, 1'b0);

        // Backpressure: register holds requester 1's result.
        for (int c = 0; c < 3; c++) begin
            cyc(4'b1111, 1'b0, 4'b0000, "bp_no_grant");
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_id",    64'(rsp_id),    64'd1);
            check("bp_rsp_diff",  64'(rsp_diff),  64'd12);
        end
        cyc(4'b1111, 1'b1, 4'b0100, "bp_release_grant");
        push(2'd2, 32'd21, 1'b0);

        // Idle cycles must not move the pointer.
        cyc(4'b0010, 1'b1, 4'b0010, "idle_ptr_grant1");
        set_op(1, 32'd100, 32'd1);
        push(2'd1, 32'd99, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cyc(4'b0000, 1'b1, 4'b0000, "idle_no_grant");
        end
        cyc(4'b1001, 1'b1, 4'b1000, "idle_ptr_grant3");
        push(2'd3, 32'd30, 1'b0);
        cyc(4'b0001, 1'b1, 4'b0001, "idle_ptr_grant0");
        push(2'd0, 32'd3, 1'b0);
        cyc(4'b0000, 1'b1, 4'b0000, "drain_before_rst");

        // Reset with a result held; it is discarded.
        cyc(4'b0010, 1'b1, 4'b0010, "pre_rst_grant");
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        check("pre_rst_id",    64'(rsp_id),    64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(rsp_valid), 64'd0);
        check("async_rst_diff",  64'(rsp_diff),  64'd0);
        req_valid = 4'b1111;
        #1;
        check("in_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        cyc(4'b1111, 1'b1, 4'b0001, "post_rst_grant0");
        push(2'd0, 32'd3, 1'b0);
        cyc(4'b0000, 1'b1, 4'b0000, "post_rst_idle");

        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            @(posedge clk);
        end
        check("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sub_share_arbiter.md
Name: sub_share_arbiter

Overview:
- Shares one 32-bit two's-complement subtractor (signed_2s_comp_sub) between N requesters.
- Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one pair per cycle and drives the muxed operands into the subtractor.
- The difference, overflow flag and requester id go into a single-entry output register with its own valid/ready handshake.
- Sits between the issue logic of the requesting units and the shared arithmetic resource.

Parameters:
- N, 4, number of requesters (2..8).
- W, 32, operand/result width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  bit i: requester i presents an operand pair.
- req_ready  out  N  bit i: pair from requester i accepted this cycle; at most one bit set.
- req_a  in  N*W  minuend of requester i at bits [i*W +: W].
- req_b  in  N*W  subtrahend of requester i at bits [i*W +: W].
- rsp_valid  out  1  output register holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  clog2(N)  index of the requester that owns the result.
- rsp_diff  out  W  req_a - req_b, modulo 2^W.
- rsp_ovf  out  1  signed overflow of the subtraction.

Behaviour:
- Reset (async on rst_n low): rsp_valid=0, rsp_diff=0, rsp_id=0, rsp_ovf=0, rr_ptr=0. req_ready=0 while in reset. An in-flight result is discarded with no response.
- Output register states:
  - EMPTY (rsp_valid=0) -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on accept (reload), or on no rsp_ready (hold).
- slot_free = !rsp_valid || rsp_ready. accept = slot_free && |req_valid.
- Grant selection: the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
- req_ready[grant] = accept. All other req_ready bits = 0.
- req_ready depends combinationally on req_valid and rsp_ready. Requesters must not gate req_valid on req_ready.
- On accept, at the next rising edge:
  - rsp_diff <= a - b, computed by the subtractor from the granted pair.
  - rsp_ovf <= (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
  - rsp_id <= grant; rsp_valid <= 1.
  - rr_ptr <= (grant+1) mod N.
- Latency: 1 cycle from req_valid&req_ready to rsp_valid.
- Throughput: 1 result per cycle while rsp_ready=1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_* stay stable, all req_ready=0 and rr_ptr holds.
- Simultaneous drain and accept in one cycle: the register reloads with the new result and rsp_valid stays 1.
- Fairness: with all N requesters continuously valid, grants rotate strictly. No requester waits more than N-1 grants.
- rr_ptr advances only on accept. Idle cycles do not move it.
- Arithmetic: wrap-around modulo 2^W. There is no saturation; overflow is reported only via rsp_ovf.
- An unselected requester may drop or change req_valid, req_a and req_b freely.

Decomposition:
- Package sub_arb_pkg holds:
  - constants SUB_W=32 and SUB_N=4;
  - typedef sub_word_t = logic [SUB_W-1:0];
  - typedef sub_id_t = logic [$clog2(SUB_N)-1:0];
  - function ovf_sub(a, b, d) for the overflow rule.
- One sub-module instance: signed_2s_comp_sub, fed by the granted-operand mux. Its diff output feeds the output register.
- Round-robin priority logic stays inline. No separate arbiter module.

Test Plan:
- Single request: requester 0 sends a=5, b=7, rsp_ready=1. Expect req_ready[0] in the same cycle; next cycle rsp_valid=1, rsp_diff=0xFFFFFFFE, rsp_ovf=0, rsp_id=0.
- Overflow: requester 2 sends a=0x80000000, b=1 -> rsp_diff=0x7FFFFFFF, ovf=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> rsp_diff=0x80000000, ovf=1.
- Rotation: all 4 requesters valid continuously, rsp_ready=1, each with a=i*10+3, b=i. Expect rsp_id sequence 0,1,2,3,0,1 on consecutive cycles with rsp_diff=3,12,21,30.
- Backpressure: hold rsp_ready=0 for 3 cycles with a result in FULL. Expect rsp_* stable, req_ready=0, no grant. Raising rsp_ready produces a drain plus a new accept in the same cycle.
- Idle pointer: grant to requester 1, idle 5 cycles, then requesters 0 and 3 valid together -> requester 3 is granted first.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1. Expect rsp_valid=0 immediately (asynchronous). After release, requester 0 is granted first when all are valid.
